// File: rtl/seven_seg_scan_mux_if.sv
// Bundle of the scanner's data-path signals. The master modport is the side that supplies
// the value/blank inputs; the slave modport is the scanner.
interface seven_seg_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    load;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic [3:0]              nibble_out;
    logic [NUM_DIGITS-1:0]   digit_en_n;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_tick;
    logic                    pending;

    modport master (
        output value_in, load, blank_in,
        input  nibble_out, digit_en_n, digit_idx, frame_tick, pending
    );

    modport slave (
        input  value_in, load, blank_in,
        output nibble_out, digit_en_n, digit_idx, frame_tick, pending
    );
endinterface

// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed seven-segment digit scanner with dead time and frame-synchronous value updates.
// Optional leading-zero suppression is enabled by defining SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 3000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    seven_seg_scan_mux_if.slave  bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_DEAD = DIV_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        ST_DEAD = 1'b0,
        ST_ON   = 1'b1
    } state_t;

    // With no dead time the slot starts directly in ON.
    localparam state_t ST_SLOT_START = (DEAD_CYCLES == 0) ? ST_ON : ST_DEAD;

    logic [DIV_W-1:0]      r_div;
    logic [IDX_W-1:0]      r_idx;
    state_t                r_state;
    logic [VAL_W-1:0]      r_display;
    logic [VAL_W-1:0]      r_pending_val;
    logic                  r_pending;
    logic [3:0]            r_nibble;
    logic [NUM_DIGITS-1:0] r_en_n;
    logic [IDX_W-1:0]      r_idx_out;
    logic                  r_frame_tick;

    logic                  w_div_last;
    logic                  w_frame_end;
    logic [3:0]            w_nibble;
    logic [NUM_DIGITS-1:0] w_lz;
    logic [NUM_DIGITS-1:0] w_en_n;

`ifdef SEVEN_SEG_LZ_BLANK_EN
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [VAL_W-1:0] v);
        logic [NUM_DIGITS-1:0] m;
        logic                  seen;
        m    = '0;
        seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (v[4*i +: 4] != 4'h0) begin
                seen = 1'b1;
            end else begin
                seen = seen;
            end
            m[i] = ~seen;
        end
        return m;
    endfunction

    assign w_lz = lz_mask(r_display);
`else
    assign w_lz = '0;
`endif

    assign w_div_last  = (r_div == DIV_LAST);
    assign w_frame_end = w_div_last && (r_idx == IDX_LAST);

    // Current-slot nibble and enable pattern, registered into the outputs below.
    always_comb begin
        w_nibble = 4'h0;
        w_en_n   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble = r_display[4*i +: 4];
            end else begin
                w_nibble = w_nibble;
            end
            if ((r_state == ST_ON) && (r_idx == IDX_W'(i)) && !bus.blank_in[i] && !w_lz[i]) begin
                w_en_n[i] = 1'b0;
            end else begin
                w_en_n[i] = 1'b1;
            end
        end
    end

    // Slot timing FSM plus registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div        <= '0;
            r_idx        <= '0;
            r_state      <= ST_SLOT_START;
            r_nibble     <= 4'h0;
            r_en_n       <= '1;
            r_idx_out    <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            if (w_div_last) begin
                r_div   <= '0;
                r_idx   <= (r_idx == IDX_LAST) ? '0 : (r_idx + IDX_W'(1));
                r_state <= ST_SLOT_START;
            end else begin
                r_div <= r_div + DIV_W'(1);
                r_idx <= r_idx;
                case (r_state)
                    ST_DEAD: r_state <= ((r_div + DIV_W'(1)) == DIV_DEAD) ? ST_ON : ST_DEAD;
                    ST_ON:   r_state <= ST_ON;
                    default: r_state <= ST_SLOT_START;
                endcase
            end
            r_nibble     <= w_nibble;
            r_en_n       <= w_en_n;
            r_idx_out    <= r_idx;
            r_frame_tick <= w_frame_end;
        end
    end

    // Double buffer: loads park in r_pending_val and commit only at the frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_display     <= '0;
            r_pending_val <= '0;
            r_pending     <= 1'b0;
        end else if (w_frame_end) begin
            r_pending_val <= r_pending_val;
            r_pending     <= 1'b0;
            if (bus.load) begin
                r_display <= bus.value_in;
            end else if (r_pending) begin
                r_display <= r_pending_val;
            end else begin
                r_display <= r_display;
            end
        end else begin
            r_display <= r_display;
            if (bus.load) begin
                r_pending_val <= bus.value_in;
                r_pending     <= 1'b1;
            end else begin
                r_pending_val <= r_pending_val;
                r_pending     <= r_pending;
            end
        end
    end

    assign bus.nibble_out = r_nibble;
    assign bus.digit_en_n = r_en_n;
    assign bus.digit_idx  = r_idx_out;
    assign bus.frame_tick = r_frame_tick;
    assign bus.pending    = r_pending;
endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Self-checking bench for seven_seg_scan_mux: directed scenarios plus random loads/blanking,
// checked every cycle against a frame/slot arithmetic model.
module tb_seven_seg_scan_mux;
    localparam int N     = 4;
    localparam int R     = 8;
    localparam int D     = 2;
    localparam int FRAME = N * R;

    logic clk = 1'b0;
    logic rst;

    seven_seg_scan_mux_if #(.NUM_DIGITS(N)) bus ();

    seven_seg_scan_mux #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(R),
        .DEAD_CYCLES(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          ticks = 0;
    int unsigned c     = 0;
    logic [15:0] m_disp = 16'h0;
    logic [15:0] m_pval = 16'h0;
    logic        m_pend = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit shown(input int idx, input logic [15:0] disp);
`ifdef SEVEN_SEG_LZ_BLANK_EN
        return (idx == 0) || ((disp >> (4 * idx)) != 16'h0);
`else
        return 1'b1;
`endif
    endfunction

    // One clock: predict from slot arithmetic, advance, then compare all outputs.
    task automatic step();
        int          div;
        int          idx;
        logic [3:0]  e_nib;
        logic [3:0]  e_en;
        logic        e_tick;
        if (rst) begin
            @(posedge clk);
            #1;
            c = 0; m_disp = 16'h0; m_pval = 16'h0; m_pend = 1'b0;
            chk("rst_en",   32'(bus.digit_en_n), 32'hF);
            chk("rst_idx",  32'(bus.digit_idx),  32'h0);
            chk("rst_nib",  32'(bus.nibble_out), 32'h0);
            chk("rst_tick", 32'(bus.frame_tick), 32'h0);
            chk("rst_pend", 32'(bus.pending),    32'h0);
            return;
        end
        div    = int'(c % R);
        idx    = int'((c / R) % N);
        e_nib  = 4'((m_disp >> (4 * idx)) & 16'hF);
        e_tick = (idx == N - 1) && (div == R - 1);
        e_en   = 4'hF;
        if ((div >= D) && !bus.blank_in[idx] && shown(idx, m_disp)) e_en[idx] = 1'b0;
        if (e_tick) begin
            if (bus.load) begin
                m_disp = bus.value_in; m_pend = 1'b0;
            end else if (m_pend) begin
                m_disp = m_pval; m_pend = 1'b0;
            end
        end else if (bus.load) begin
            m_pval = bus.value_in; m_pend = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("en",   32'(bus.digit_en_n), 32'(e_en));
        chk("idx",  32'(bus.digit_idx),  32'(idx));
        chk("nib",  32'(bus.nibble_out), 32'(e_nib));
        chk("tick", 32'(bus.frame_tick), 32'(e_tick));
        chk("pend", 32'(bus.pending),    32'(m_pend));
        if (bus.frame_tick) ticks++;
        c++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic run_to_phase(input int ph);
        for (int k = 0; k < FRAME && (int'(c % FRAME) != ph); k++) step();
    endtask

    task automatic load_now(input logic [15:0] v);
        bus.value_in = v;
        bus.load     = 1'b1;
        step();
        bus.load     = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.value_in = 16'h0;
        bus.load     = 1'b0;
        bus.blank_in = 4'h0;
        step();
        step();
        rst = 1'b0;

        // Scan from release: two frames, two ticks.
        ticks = 0;
        run(2 * FRAME);
        chk("tick_count", 32'(ticks), 32'd2);

        // Mid-frame load is held until the boundary.
        run_to_phase(10);
        load_now(16'h1A3F);
        chk("pend_set", 32'(bus.pending), 32'h1);
        run(2 * FRAME);

        // Last write wins.
        run_to_phase(5);
        load_now(16'h1111);
        run(6);
        load_now(16'h2222);
        run(2 * FRAME);

        // Load exactly on the boundary cycle.
        run_to_phase(FRAME - 1);
        load_now(16'hBEEF);
        chk("bnd_pend", 32'(bus.pending), 32'h0);
        step();
        chk("beef_d0", 32'(bus.nibble_out), 32'hF);
        run(FRAME);

        // Forced blank of digit 2.
        bus.blank_in = 4'b0100;
        run(2 * FRAME);
        bus.blank_in = 4'b0000;

        // Leading-zero candidate.
        load_now(16'h0042);
        run(2 * FRAME);

        // Randomized loads and blanking.
        for (int k = 0; k < 600; k++) begin
            bus.load     = ($urandom_range(0, 7) == 0);
            bus.value_in = 16'($urandom);
            if ($urandom_range(0, 15) == 0) bus.blank_in = 4'($urandom);
            step();
        end
        bus.load     = 1'b0;
        bus.blank_in = 4'h0;

        // Reset mid-slot at digit 2, then scan display 0 again.
        run_to_phase(2 * R + 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(2 * FRAME);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan_mux.md
Name: seven_seg_scan_mux

Overview:
- Time-multiplexed scanner that sits directly upstream of the nibble-to-seven-segment decoder.
- Holds a multi-digit hex value and presents one nibble per time slot on `nibble_out`, which feeds the decoder.
- Drives the matching active-low digit enable and inserts anti-ghosting dead time between digits.
- Value updates are double-buffered and take effect only at frame boundaries, so the display never tears.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; range 1..8.
- REFRESH_DIV, 3000: clock cycles per digit slot; minimum 2.
- DEAD_CYCLES, 16: cycles at the start of each slot with all digits disabled; must be less than REFRESH_DIV; may be 0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- value_in  in  4*NUM_DIGITS  hex value; bits [3:0] are digit 0 (rightmost)
- load  in  1  one-cycle strobe; captures value_in
- blank_in  in  NUM_DIGITS  per-digit force-blank, active-high, sampled every cycle
- nibble_out  out  4  nibble for the current digit, to the decoder
- digit_en_n  out  NUM_DIGITS  digit enables, active-low, at most one low at a time
- digit_idx  out  clog2(NUM_DIGITS), min 1  current slot index
- frame_tick  out  1  one-cycle pulse on the last cycle of the final slot
- pending  out  1  high while a loaded value waits for the frame boundary

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-high.
  - All outputs are registered.
- Reset values:
  - Internal: div counter 0, slot index 0, state DEAD, display_reg 0, pending_reg 0.
  - Outputs: nibble_out 0, digit_en_n all ones, digit_idx 0, frame_tick 0, pending 0.
- Slot counter:
  - div counts 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, the slot index increments modulo NUM_DIGITS (NUM_DIGITS-1 wraps to 0).
- State machine, evaluated per slot:
  - DEAD while div < DEAD_CYCLES; ON while div >= DEAD_CYCLES.
  - DEAD -> ON when div reaches DEAD_CYCLES.
  - ON -> DEAD on the div wrap.
  - If DEAD_CYCLES = 0, DEAD is skipped and the block is in ON every cycle.
- Outputs per cycle, registered from current state, so visible one cycle later:
  - nibble_out = display_reg[4*idx+3 : 4*idx], held for the whole slot including dead time.
  - digit_idx = idx.
  - digit_en_n: all ones in DEAD; in ON, bit idx is low unless blank_in[idx] is high.
- frame_tick: high for exactly one cycle, when idx = NUM_DIGITS-1 and div = REFRESH_DIV-1.
- Load and frame-boundary handling:
  - load: pending_reg <= value_in and pending <= 1. A later load before the boundary overwrites pending_reg (last write wins).
  - At the frame boundary (the frame_tick condition) with pending set: display_reg <= pending_reg and pending <= 0.
  - load on the boundary cycle itself: value_in goes straight into display_reg and pending stays 0.
- Reset mid-slot: everything returns to reset values on the next edge; the scan restarts at digit 0 in DEAD.
- Frame period is NUM_DIGITS*REFRESH_DIV cycles. At 12 MHz with defaults: 4 kHz per digit, 1 kHz frame.

Optional Feature:
- Macro: SEVEN_SEG_LZ_BLANK_EN.
- Defined (leading-zero suppression):
  - Digits above the highest nonzero nibble of display_reg are blanked: their digit_en_n bit is held high in ON.
  - Digit 0 is never suppressed, so 0x0000 shows "0".
  - Suppression is recomputed whenever display_reg changes.
  - It is ORed with blank_in.
- Not defined: only blank_in affects blanking; all digits are shown.

Test Plan:
- Reset and scan, with NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2:
  - Stimulus: release rst.
  - Expect: digit_en_n = 1111 for 2 cycles, then 1110 for 6 cycles, then digit 1 follows the same pattern.
  - Expect: digit_idx sequence 0,1,2,3,0; frame_tick pulses every 32 cycles.
- Display content:
  - Stimulus: load value_in=0x1A3F mid-frame.
  - Expect: pending=1; nibbles unchanged until frame_tick.
  - Expect: the next frame shows nibble_out F,3,A,1 for digits 0..3; pending=0.
- Double load:
  - Stimulus: load 0x1111, then load 0x2222 in the same frame.
  - Expect: the next frame shows 2,2,2,2.
- Boundary load:
  - Stimulus: load 0xBEEF on the frame_tick cycle.
  - Expect: the immediately following frame shows F,E,E,B; pending never rises.
- Blanking and reset:
  - Stimulus: blank_in=0100.
  - Expect: digit 2 enable stays high through its whole slot while nibble_out is still driven.
  - Stimulus: assert rst mid-slot at digit 2.
  - Expect: next cycle digit_en_n=1111, digit_idx=0, nibble_out=0.
- With SEVEN_SEG_LZ_BLANK_EN:
  - display 0x0042: digits 3 and 2 are blanked.
  - display 0x0000: only digit 0 is enabled.
  - Without the macro, all four digits are enabled.
